wb_dma_master: RTL and testbench

- Wishbone pipelined (B4, with stall) bus master that copies a block of 32-bit words from a source address to a destination address.
- Sits on the shared-bus interconnect as an additional master beside the CPU instruction/data ports and the debug module.
- Targets any slave on the bus: RAM, DDR user ports, VERA and so on.
- Each copy runs as alternating read bursts into a local buffer and write bursts out of that buffer.

---
 rtl/wb_dma_pkg.sv | 23 ++
 rtl/wb_dma_buf.sv | 48 ++++
 rtl/wb_dma_master.sv | 197 +++++++++++++++++++
 tb/tb_wb_dma_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone DMA master and its buffer.
package wb_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    GAP,
    FINISH
  } state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] ADR_MASK   = ~(WORD_BYTES - 32'd1);
  localparam logic [3:0]  SEL_ALL    = 4'hF;

  // Width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_dma_buf.sv
// First-word-fall-through FIFO that holds one burst of words between the
// read and write phases of a copy.
module wb_dma_buf
  import wb_dma_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_dma_master.sv
// Wishbone B4 pipelined DMA master: copies len_words words from src to dst
// as alternating read bursts into a local buffer and write bursts out of it.
//
// state   | meaning
// IDLE    | waiting for start
// RD_REQ  | issuing read requests for the current chunk
// RD_WAIT | all reads issued, collecting remaining acks
// WR_REQ  | issuing write requests from the buffer
// WR_WAIT | all writes issued, collecting remaining acks
// GAP     | one idle cycle (cyc=0) between phases
// FINISH  | done pulse, back to IDLE
module wb_dma_master
  import wb_dma_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_adr,
  input  logic [31:0] dst_adr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] wbm_adr,
  output logic [31:0] wbm_dat_m,
  input  logic [31:0] wbm_dat_s,
  output logic [3:0]  wbm_sel,
  output logic        wbm_we,
  output logic        wbm_cyc,
  output logic        wbm_stb,
  input  logic        wbm_stall,
  input  logic        wbm_ack,
  input  logic        wbm_err
);
  localparam int CW = cnt_width(BURST_LEN);

  state_e        state;
  logic          gap_to_wr;
  logic [31:0]   cur_src, cur_dst, tmo_cnt, buf_head;
  logic [15:0]   remaining;
  logic [CW-1:0] chunk, issued, acked, outstanding;
  logic          active, rd_phase, accept, ack_ok, err_hit, tmo_hit, abort;
  logic          buf_push, buf_pop, buf_full, buf_empty;

  function automatic logic [CW-1:0] chunk_of(input logic [15:0] rem);
    return (rem >= 16'(BURST_LEN)) ? CW'(BURST_LEN) : CW'(rem);
  endfunction

  assign active      = state inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT};
  assign rd_phase    = state inside {RD_REQ, RD_WAIT};
  assign outstanding = issued - acked;
  assign accept      = wbm_stb && !wbm_stall;
  // Acks/errors with nothing outstanding are stray and ignored; err beats ack.
  assign ack_ok      = active && (outstanding != '0) && wbm_ack && !wbm_err;
  assign err_hit     = active && (outstanding != '0) && wbm_err;
  assign tmo_hit     = (TIMEOUT != 0) && active && (outstanding != '0) &&
                       !wbm_ack && (tmo_cnt == 32'd1);
  assign abort       = err_hit || tmo_hit;
  assign buf_push    = rd_phase && ack_ok && !buf_full;
  assign buf_pop     = (state == WR_REQ) && accept && !buf_empty;
  assign wbm_dat_m   = wbm_we ? buf_head : '0;

  wb_dma_buf #(.DEPTH(BURST_LEN)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (abort),
    .din   (wbm_dat_s),
    .dout  (buf_head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap_to_wr <= 1'b0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      chunk     <= '0;
      issued    <= '0;
      acked     <= '0;
      tmo_cnt   <= 32'(TIMEOUT);
      wbm_cyc   <= 1'b0;
      wbm_stb   <= 1'b0;
      wbm_we    <= 1'b0;
      wbm_sel   <= '0;
      wbm_adr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      // Down-counter reloads on every ack and while nothing is in flight.
      if (ack_ok || outstanding == '0) tmo_cnt <= 32'(TIMEOUT);
      else                             tmo_cnt <= tmo_cnt - 32'd1;
      if (ack_ok) acked <= acked + CW'(1);
      if (accept) begin
        issued  <= issued + CW'(1);
        wbm_adr <= wbm_adr + WORD_BYTES;
        if (wbm_we) cur_dst <= cur_dst + WORD_BYTES;
        else        cur_src <= cur_src + WORD_BYTES;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= src_adr & ADR_MASK;
            cur_dst   <= dst_adr & ADR_MASK;
            remaining <= len_words;
            err       <= 1'b0;
            if (len_words == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              busy    <= 1'b1;
              chunk   <= chunk_of(len_words);
              issued  <= '0;
              acked   <= '0;
              wbm_cyc <= 1'b1;
              wbm_stb <= 1'b1;
              wbm_we  <= 1'b0;
              wbm_sel <= SEL_ALL;
              wbm_adr <= src_adr & ADR_MASK;
              state   <= RD_REQ;
            end
          end
        end
        RD_REQ, WR_REQ: begin
          if (accept && (issued + CW'(1) == chunk)) begin
            wbm_stb <= 1'b0;
            state   <= (state == RD_REQ) ? RD_WAIT : WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (ack_ok && (acked + CW'(1) == chunk)) begin
            wbm_cyc   <= 1'b0;
            gap_to_wr <= 1'b1;
            state     <= GAP;
          end
        end
        WR_WAIT: begin
          if (ack_ok && (acked + CW'(1) == chunk)) begin
            wbm_cyc   <= 1'b0;
            wbm_we    <= 1'b0;
            gap_to_wr <= 1'b0;
            remaining <= remaining - 16'(chunk);
            if (remaining == 16'(chunk)) begin
              wbm_sel <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= FINISH;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          issued  <= '0;
          acked   <= '0;
          wbm_cyc <= 1'b1;
          wbm_stb <= 1'b1;
          if (gap_to_wr) begin
            wbm_we  <= 1'b1;
            wbm_adr <= cur_dst;
            state   <= WR_REQ;
          end else begin
            chunk   <= chunk_of(remaining);
            wbm_adr <= cur_src;
            state   <= RD_REQ;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (abort) begin
        wbm_cyc <= 1'b0;
        wbm_stb <= 1'b0;
        wbm_we  <= 1'b0;
        wbm_sel <= '0;
        issued  <= '0;
        acked   <= '0;
        busy    <= 1'b0;
        err     <= 1'b1;
        done    <= 1'b1;
        state   <= FINISH;
      end
    end
  end

endmodule

// File: tb/tb_wb_dma_master.sv
// Self-checking bench for wb_dma_master: table of copy jobs against a
// memory-backed pipelined slave model, plus reset and random sequences.
module tb_wb_dma_master;
  localparam int BL  = 8;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, err;
  logic [31:0] src_adr, dst_adr, wbm_adr, wbm_dat_m, wbm_dat_s;
  logic [15:0] len_words;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb, wbm_stall, wbm_ack, wbm_err;

  always #5 clk = ~clk;

  wb_dma_master #(.BURST_LEN(BL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
    .len_words(len_words), .busy(busy), .done(done), .err(err),
    .wbm_adr(wbm_adr), .wbm_dat_m(wbm_dat_m), .wbm_dat_s(wbm_dat_s),
    .wbm_sel(wbm_sel), .wbm_we(wbm_we), .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb),
    .wbm_stall(wbm_stall), .wbm_ack(wbm_ack), .wbm_err(wbm_err)
  );

  typedef struct {
    int len; logic [31:0] src; logic [31:0] dst;
    int stall; int dly; int err_at; bit no_ack; bit poke;
    bit exp_err; int exp_wr; int exp_bursts;
  } vec_t;

  typedef struct { int idx; bit we; int rdy; } req_t;

  int checks = 0, failures = 0;
  logic [31:0] mem [1024];
  req_t pend[$];
  int cyc_no = 0, done_cnt = 0, bursts = 0, reads = 0, writes = 0, rd_acks = 0, viol = 0;
  int stall_pct = 0, max_dly = 0, err_at = 0;
  bit no_ack = 0, abort_ok = 0, err_chk_pend = 0, err_follow_ok = 0;
  bit prev_cyc = 0, prev_stalled = 0, prev_we = 0;
  logic [31:0] prev_adr = '0;
  vec_t vec [12];

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pipelined slave: in-order acks after 1+0..max_dly cycles, random stall.
  initial begin
    req_t r;
    wbm_ack = 0; wbm_err = 0; wbm_stall = 0; wbm_dat_s = '0;
    forever begin
      @(posedge clk); #1;
      cyc_no++;
      if (done) done_cnt++;
      if (wbm_cyc && !prev_cyc) bursts++;
      if (wbm_stb && !wbm_cyc) viol++;
      if (prev_stalled && wbm_stb && (wbm_adr != prev_adr || wbm_we != prev_we)) viol++;
      if (prev_cyc && !wbm_cyc && pend.size() != 0 && !abort_ok) viol++;
      if (err_chk_pend) begin
        err_follow_ok = !wbm_cyc && !wbm_stb && done;
        err_chk_pend = 0;
      end
      if (!wbm_cyc) pend.delete();
      wbm_ack = 0; wbm_err = 0; wbm_dat_s = $urandom;
      if (wbm_cyc && pend.size() > 0 && !no_ack && pend[0].rdy <= cyc_no) begin
        r = pend.pop_front();
        wbm_ack = 1;
        if (!r.we) begin
          rd_acks++;
          wbm_dat_s = mem[r.idx];
          if (rd_acks == err_at) begin wbm_err = 1; err_chk_pend = 1; end
        end
      end
      wbm_stall = wbm_cyc && ($urandom_range(99) < stall_pct);
      if (wbm_stb && !wbm_stall) begin
        r.idx = widx(wbm_adr); r.we = wbm_we; r.rdy = cyc_no + 1 + $urandom_range(max_dly);
        pend.push_back(r);
        if (wbm_we) begin mem[r.idx] = wbm_dat_m; writes++; end
        else reads++;
      end
      prev_cyc = wbm_cyc; prev_stalled = wbm_stb && wbm_stall;
      prev_adr = wbm_adr; prev_we = wbm_we;
    end
  end

  task automatic run_copy(input vec_t v, input int tag);
    logic [31:0] s, d;
    logic [31:0] exp_q[$];
    int waited, bad;
    s = v.src & 32'hFFFF_FFFC; d = v.dst & 32'hFFFF_FFFC;
    for (int i = 0; i < v.len; i++) mem[widx(d + 32'(4*i))] = $urandom;
    for (int i = 0; i < v.len; i++) begin
      mem[widx(s + 32'(4*i))] = $urandom;
      exp_q.push_back(mem[widx(s + 32'(4*i))]);
    end
    stall_pct = v.stall; max_dly = v.dly; err_at = v.err_at; no_ack = v.no_ack;
    abort_ok = (v.err_at != 0) || v.no_ack;
    done_cnt = 0; bursts = 0; reads = 0; writes = 0; rd_acks = 0; viol = 0; err_follow_ok = 0;
    @(negedge clk);
    start = 1; src_adr = v.src; dst_adr = v.dst; len_words = 16'(v.len);
    @(negedge clk);
    start = 0;
    if (v.len == 0) chk($sformatf("v%0d_zero_len", tag), {done, busy, err, wbm_cyc}, 4'b1000);
    else chk($sformatf("v%0d_first_req", tag), {wbm_cyc, wbm_stb, busy, err}, 4'b1110);
    waited = 0;
    while (busy && waited < 2000) begin
      @(negedge clk);
      waited++;
      start = v.poke && (waited == 10);
      if (start) begin src_adr = 32'h0; dst_adr = 32'hE00; len_words = 16'd3; end
    end
    start = 0;
    chk($sformatf("v%0d_finished", tag), waited < 2000, 1);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_done_cnt", tag), done_cnt, 1);
    chk($sformatf("v%0d_err", tag), err, v.exp_err);
    chk($sformatf("v%0d_writes", tag), writes, v.exp_wr);
    chk($sformatf("v%0d_bursts", tag), bursts, v.exp_bursts);
    chk($sformatf("v%0d_protocol", tag), viol, 0);
    if (!v.exp_err) begin
      chk($sformatf("v%0d_reads", tag), reads, v.len);
      bad = 0;
      for (int i = 0; i < v.len; i++)
        if (mem[widx(d + 32'(4*i))] !== exp_q[i]) bad++;
      chk($sformatf("v%0d_data_bad_words", tag), bad, 0);
    end
    if (v.err_at != 0) chk($sformatf("v%0d_err_next_cycle", tag), err_follow_ok, 1);
    if (v.no_ack) chk($sformatf("v%0d_timeout_window", tag),
                      (waited >= TMO - 5) && (waited <= TMO + 5), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int waited;
    vec_t rv;
    rst = 1; start = 0; src_adr = '0; dst_adr = '0; len_words = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {wbm_cyc, wbm_stb, wbm_we, wbm_sel, busy, done, err}, 0);
    chk("reset_bus", {wbm_adr, wbm_dat_m}, 0);
    rst = 0;

    //          len  src            dst         stl dly err na pk  eerr ewr ebur
    vec[0]  = '{5,  32'h100,       32'h200,    0,  0,  0,  0, 0,  0,   5,  2};
    vec[1]  = '{20, 32'h400,       32'h800,    0,  0,  0,  0, 0,  0,   20, 6};
    vec[2]  = '{20, 32'h600,       32'hA00,    50, 3,  0,  0, 0,  0,   20, 6};
    vec[3]  = '{6,  32'h100,       32'h200,    0,  0,  3,  0, 0,  1,   0,  1};
    vec[4]  = '{0,  32'h100,       32'h200,    0,  0,  0,  0, 0,  0,   0,  0};
    vec[5]  = '{20, 32'h400,       32'h800,    30, 2,  0,  0, 1,  0,   20, 6};
    vec[6]  = '{8,  32'h140,       32'h240,    50, 3,  0,  0, 0,  0,   8,  2};
    vec[7]  = '{1,  32'h180,       32'h280,    0,  1,  0,  0, 0,  0,   1,  2};
    vec[8]  = '{9,  32'h1C0,       32'h2C0,    20, 0,  0,  0, 0,  0,   9,  4};
    vec[9]  = '{4,  32'hFFFF_FFF8, 32'hC00,    0,  0,  0,  0, 0,  0,   4,  2};
    vec[10] = '{17, 32'h106,       32'h302,    30, 2,  0,  0, 0,  0,   17, 6};
    vec[11] = '{4,  32'h500,       32'h900,    0,  0,  0,  1, 0,  1,   0,  1};
    for (int i = 0; i < 12; i++) run_copy(vec[i], i);

    // Reset in the middle of the write phase.
    stall_pct = 0; max_dly = 0; err_at = 0; no_ack = 0; abort_ok = 1;
    @(negedge clk);
    start = 1; src_adr = 32'h400; dst_adr = 32'h800; len_words = 16'd20;
    @(negedge clk);
    start = 0;
    waited = 0;
    while (!(wbm_we && wbm_stb) && waited < 500) begin @(negedge clk); waited++; end
    chk("rst_reached_wr_req", waited < 500, 1);
    done_cnt = 0;
    rst = 1;
    @(negedge clk);
    chk("rst_mid_ctrl", {wbm_cyc, wbm_stb, wbm_we, wbm_sel, busy, done, err}, 0);
    chk("rst_mid_bus", {wbm_adr, wbm_dat_m}, 0);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_idle", {wbm_cyc, busy}, 0);
    run_copy(vec[1], 20);

    // Random jobs: data and lengths random, expectations from plain arithmetic.
    for (int k = 0; k < 6; k++) begin
      rv.len = $urandom_range(30, 1);
      rv.src = 32'h000 + 32'(4 * $urandom_range(160));
      rv.dst = 32'h800 + 32'(4 * $urandom_range(160));
      rv.stall = $urandom_range(60); rv.dly = $urandom_range(3);
      rv.err_at = 0; rv.no_ack = 0; rv.poke = 0; rv.exp_err = 0;
      rv.exp_wr = rv.len;
      rv.exp_bursts = 2 * ((rv.len + BL - 1) / BL);
      run_copy(rv, 30 + k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
